// File: rtl/mem_ctrl_queued.sv
// mem_ctrl_queued: queued write/read memory controller with address-tagged returns.
// Optional periodic refresh stall is enabled by defining MEM_CTRL_REFRESH_EN.
module mem_ctrl_queued #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned Q_DEPTH        = 4,
    parameter int unsigned RD_LAT         = 2,
    parameter int unsigned REFRESH_PERIOD = 64,
    parameter int unsigned REFRESH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_ret_ack,
    output logic [ADDR_W-1:0] wr_ret_address,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_address,
    output logic              rd_ready,
    output logic              rd_ret_ack,
    output logic [ADDR_W-1:0] rd_ret_address,
    output logic [DATA_W-1:0] rd_ret_data,
    output logic              rd_ret_err,
    output logic              refresh_busy
);
    localparam int unsigned PW  = $clog2(Q_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW1 = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wq_addr [Q_DEPTH];
    logic [DATA_W-1:0] wq_data [Q_DEPTH];
    logic [ADDR_W-1:0] rq_addr [Q_DEPTH];

    logic [PW-1:0] wq_wp_q, wq_wp_d, wq_rp_q, wq_rp_d;
    logic [PW-1:0] rq_wp_q, rq_wp_d, rq_rp_q, rq_rp_d;
    logic [CW-1:0] wq_cnt_q, wq_cnt_d, rq_cnt_q, rq_cnt_d;
    logic wr_ready_q, wr_ready_d, rd_ready_q, rd_ready_d;
    logic wr_ret_ack_q, wr_ret_ack_d, rd_ret_ack_q, rd_ret_ack_d, rd_ret_err_q, rd_ret_err_d;
    logic [ADDR_W-1:0] wr_ret_address_q, wr_ret_address_d, rd_ret_address_q, rd_ret_address_d;
    logic [DATA_W-1:0] rd_ret_data_q, rd_ret_data_d;
    logic [RD_LAT-1:0]             pv_q, pv_d, pe_q, pe_d;
    logic [RD_LAT-1:0][ADDR_W-1:0] pa_q, pa_d;
    logic [RD_LAT-1:0][DATA_W-1:0] pd_q, pd_d;

    logic issue_ok, wr_push, wr_pop, rd_push, rd_pop, w_in, r_in, bypass;
    logic [ADDR_W-1:0] wh_addr, rh_addr;
    logic [DATA_W-1:0] wh_data, rd_word;

`ifdef MEM_CTRL_REFRESH_EN
    localparam int unsigned TW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int unsigned LW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    typedef enum logic {ACTIVE, REFRESH} state_t;
    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [LW-1:0] rlen_q, rlen_d;
    logic          refresh_busy_q, refresh_busy_d;

    // Refresh scheduler: free-running period counter and ACTIVE/REFRESH FSM.
    always_comb begin
        state_d        = state_q;
        rlen_d         = rlen_q;
        tick_d         = (tick_q == TW'(REFRESH_PERIOD - 1)) ? '0 : tick_q + TW'(1);
        case (state_q)
            ACTIVE: begin
                if (tick_q == TW'(REFRESH_PERIOD - 1)) begin
                    state_d = REFRESH;
                    rlen_d  = '0;
                end
            end
            REFRESH: begin
                if (rlen_q == LW'(REFRESH_CYCLES - 1)) state_d = ACTIVE;
                else                                   rlen_d  = rlen_q + LW'(1);
            end
            default: state_d = ACTIVE;
        endcase
        issue_ok       = (state_q == ACTIVE);
        refresh_busy_d = (state_d == REFRESH);
    end

    // Refresh state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ACTIVE;
            tick_q         <= '0;
            rlen_q         <= '0;
            refresh_busy_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_q         <= tick_d;
            rlen_q         <= rlen_d;
            refresh_busy_q <= refresh_busy_d;
        end
    end
    assign refresh_busy = refresh_busy_q;
`else
    assign issue_ok     = 1'b1;
    assign refresh_busy = 1'b0;
`endif

    // Queue control, issue with write-first bypass, read pipeline and return fields.
    always_comb begin
        wr_push  = wr_en && (wq_cnt_q != CW'(Q_DEPTH));
        rd_push  = rd_en && (rq_cnt_q != CW'(Q_DEPTH));
        wr_pop   = issue_ok && (wq_cnt_q != '0);
        rd_pop   = issue_ok && (rq_cnt_q != '0);
        wh_addr  = wq_addr[wq_rp_q];
        wh_data  = wq_data[wq_rp_q];
        rh_addr  = rq_addr[rq_rp_q];
        w_in     = ({1'b0, wh_addr} < AW1'(DEPTH));
        r_in     = ({1'b0, rh_addr} < AW1'(DEPTH));
        bypass   = wr_pop && w_in && (wh_addr == rh_addr);
        rd_word  = !r_in ? '0 : (bypass ? wh_data : mem[rh_addr[IW-1:0]]);

        wq_wp_d  = wq_wp_q + PW'(wr_push);
        wq_rp_d  = wq_rp_q + PW'(wr_pop);
        wq_cnt_d = wq_cnt_q + CW'(wr_push) - CW'(wr_pop);
        rq_wp_d  = rq_wp_q + PW'(rd_push);
        rq_rp_d  = rq_rp_q + PW'(rd_pop);
        rq_cnt_d = rq_cnt_q + CW'(rd_push) - CW'(rd_pop);
        wr_ready_d = (wq_cnt_d != CW'(Q_DEPTH));
        rd_ready_d = (rq_cnt_d != CW'(Q_DEPTH));

        pv_d    = pv_q;
        pa_d    = pa_q;
        pd_d    = pd_q;
        pe_d    = pe_q;
        pv_d[0] = rd_pop;
        pa_d[0] = rh_addr;
        pd_d[0] = rd_word;
        pe_d[0] = !r_in;
        for (int k = 1; k < RD_LAT; k++) begin
            pv_d[k] = pv_q[k-1];
            pa_d[k] = pa_q[k-1];
            pd_d[k] = pd_q[k-1];
            pe_d[k] = pe_q[k-1];
        end

        wr_ret_ack_d     = wr_pop;
        wr_ret_address_d = wr_pop ? wh_addr : wr_ret_address_q;
        rd_ret_ack_d     = pv_q[RD_LAT-1];
        rd_ret_address_d = pv_q[RD_LAT-1] ? pa_q[RD_LAT-1] : rd_ret_address_q;
        rd_ret_data_d    = pv_q[RD_LAT-1] ? pd_q[RD_LAT-1] : rd_ret_data_q;
        rd_ret_err_d     = pv_q[RD_LAT-1] ? pe_q[RD_LAT-1] : rd_ret_err_q;
    end

    // Control and output registers; reset drops queued and in-flight requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wq_wp_q <= '0; wq_rp_q <= '0; wq_cnt_q <= '0;
            rq_wp_q <= '0; rq_rp_q <= '0; rq_cnt_q <= '0;
            wr_ready_q <= 1'b1; rd_ready_q <= 1'b1;
            pv_q <= '0; pa_q <= '0; pd_q <= '0; pe_q <= '0;
            wr_ret_ack_q <= 1'b0; wr_ret_address_q <= '0;
            rd_ret_ack_q <= 1'b0; rd_ret_address_q <= '0;
            rd_ret_data_q <= '0;  rd_ret_err_q <= 1'b0;
        end else begin
            wq_wp_q <= wq_wp_d; wq_rp_q <= wq_rp_d; wq_cnt_q <= wq_cnt_d;
            rq_wp_q <= rq_wp_d; rq_rp_q <= rq_rp_d; rq_cnt_q <= rq_cnt_d;
            wr_ready_q <= wr_ready_d; rd_ready_q <= rd_ready_d;
            pv_q <= pv_d; pa_q <= pa_d; pd_q <= pd_d; pe_q <= pe_d;
            wr_ret_ack_q <= wr_ret_ack_d; wr_ret_address_q <= wr_ret_address_d;
            rd_ret_ack_q <= rd_ret_ack_d; rd_ret_address_q <= rd_ret_address_d;
            rd_ret_data_q <= rd_ret_data_d; rd_ret_err_q <= rd_ret_err_d;
        end
    end

    // Queue entry storage; contents are qualified by the occupancy counters.
    always_ff @(posedge clk) begin
        if (wr_push) begin
            wq_addr[wq_wp_q] <= wr_address;
            wq_data[wq_wp_q] <= wr_data;
        end
        if (rd_push) rq_addr[rq_wp_q] <= rd_address;
    end

    // Storage array write port; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_pop && w_in) mem[wh_addr[IW-1:0]] <= wh_data;
    end

    assign wr_ready       = wr_ready_q;
    assign rd_ready       = rd_ready_q;
    assign wr_ret_ack     = wr_ret_ack_q;
    assign wr_ret_address = wr_ret_address_q;
    assign rd_ret_ack     = rd_ret_ack_q;
    assign rd_ret_address = rd_ret_address_q;
    assign rd_ret_data    = rd_ret_data_q;
    assign rd_ret_err     = rd_ret_err_q;
endmodule

// File: tb/tb_mem_ctrl_queued.sv
// Scoreboard bench for mem_ctrl_queued (default parameters).
module tb_mem_ctrl_queued;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [15:0] wr_address, wr_data, rd_address;
    logic        wr_ready, wr_ret_ack, rd_ready, rd_ret_ack, rd_ret_err, refresh_busy;
    logic [15:0] wr_ret_address, rd_ret_address, rd_ret_data;

    mem_ctrl_queued dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data), .wr_ready(wr_ready),
        .wr_ret_ack(wr_ret_ack), .wr_ret_address(wr_ret_address),
        .rd_en(rd_en), .rd_address(rd_address), .rd_ready(rd_ready),
        .rd_ret_ack(rd_ret_ack), .rd_ret_address(rd_ret_address),
        .rd_ret_data(rd_ret_data), .rd_ret_err(rd_ret_err),
        .refresh_busy(refresh_busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] addr; int cyc; } wexp_t;
    typedef struct { logic [15:0] addr; logic [15:0] data; logic err; int cyc; } rexp_t;

    wexp_t       wq[$];
    rexp_t       rq[$];
    logic [15:0] mdl [int];
    int          cyc;
    int          checks = 0;
    int          errors = 0;
    int          post_rst_acks;

    // Edge counter: edge 1 is the first rising edge after reset release.
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever a return acknowledge is presented.
    always @(negedge clk) begin
        if (!rst && wr_ret_ack) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL wr_ret unexpected addr=%h cyc=%0d", wr_ret_address, cyc);
            end else begin
                wexp_t e;
                bit lat_ok;
                e = wq.pop_front();
                lat_ok = 1'b1;
`ifndef MEM_CTRL_REFRESH_EN
                lat_ok = (cyc == e.cyc);
`endif
                if (wr_ret_address !== e.addr || !lat_ok) begin
                    errors++;
                    $display("FAIL wr_ret actual addr=%h cyc=%0d required addr=%h cyc=%0d",
                             wr_ret_address, cyc, e.addr, e.cyc);
                end
            end
        end
        if (!rst && rd_ret_ack) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL rd_ret unexpected addr=%h data=%h cyc=%0d", rd_ret_address, rd_ret_data, cyc);
            end else begin
                rexp_t e;
                bit lat_ok;
                e = rq.pop_front();
                lat_ok = 1'b1;
`ifndef MEM_CTRL_REFRESH_EN
                lat_ok = (cyc == e.cyc);
`endif
                if (rd_ret_address !== e.addr || rd_ret_data !== e.data || rd_ret_err !== e.err || !lat_ok) begin
                    errors++;
                    $display("FAIL rd_ret actual addr=%h data=%h err=%b cyc=%0d required addr=%h data=%h err=%b cyc=%0d",
                             rd_ret_address, rd_ret_data, rd_ret_err, cyc, e.addr, e.data, e.err, e.cyc);
                end
            end
        end
    end

    // Drive one request slot from a negedge; pushes expected returns for accepted requests.
    task automatic issue(input bit we, input logic [15:0] wa, input logic [15:0] wd,
                         input bit re, input logic [15:0] ra);
        int e;
        for (int t = 0; t < 50 && !((!we || wr_ready) && (!re || rd_ready)); t++) @(negedge clk);
        if ((we && !wr_ready) || (re && !rd_ready)) begin
            checks++;
            errors++;
            $display("FAIL issue_ready actual wr_ready=%b rd_ready=%b required 1", wr_ready, rd_ready);
        end
        wr_en = we; wr_address = wa; wr_data = wd;
        rd_en = re; rd_address = ra;
        e = cyc + 1;
        if (we && wr_ready) begin
            wq.push_back('{wa, e + 1});
            if (wa < 16'h0400) mdl[int'(wa)] = wd;
        end
        if (re && rd_ready) begin
            if (ra < 16'h0400) rq.push_back('{ra, mdl[int'(ra)], 1'b0, e + RD_LAT + 1});
            else               rq.push_back('{ra, 16'h0000, 1'b1, e + RD_LAT + 1});
        end
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0;
        wr_address = '0; wr_data = '0; rd_address = '0;
        idle(2);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_rd_ready", 32'(rd_ready), 32'd1);
        check("rst_acks", {30'd0, wr_ret_ack, rd_ret_ack}, 32'd0);
        check("rst_ret_fields", {wr_ret_address, rd_ret_address}, 32'd0);
        check("rst_rd_data_err", {15'd0, rd_ret_err, rd_ret_data}, 32'd0);
        check("rst_refresh_busy", 32'(refresh_busy), 32'd0);
        rst = 1'b0;

        // Basic write then read back.
        issue(1, 16'h0005, 16'h00AA, 0, 16'h0);
        for (int t = 0; t < 20 && !wr_ret_ack; t++) @(negedge clk);
        @(negedge clk);
        check("idle_hold_wr", {15'd0, wr_ret_ack, wr_ret_address}, 32'h0000_0005);
        issue(0, 16'h0, 16'h0, 1, 16'h0005);
        idle(5);

        // Same-edge write/read hazard: write-first bypass.
        issue(1, 16'h0010, 16'h1234, 1, 16'h0010);
        idle(5);

        // Streaming writes then back-to-back reads.
        for (int i = 0; i < 16; i++) issue(1, 16'(i), 16'(i + 1), 0, 16'h0);
        for (int i = 0; i < 16; i++) issue(0, 16'h0, 16'h0, 1, 16'(i));
        idle(6);
        check("rd_data_hold", 32'(rd_ret_data), 32'h0000_0010);

        // Out-of-range write/read and aliasing check on address 0.
        issue(1, 16'h0400, 16'hBEEF, 0, 16'h0);
        issue(0, 16'h0, 16'h0, 1, 16'h0400);
        issue(0, 16'h0, 16'h0, 1, 16'h0000);
        idle(6);

`ifdef MEM_CTRL_REFRESH_EN
        // Backpressure while refresh stalls issue.
        begin
            int acc;
            bit saw_full;
            acc = 0;
            saw_full = 1'b0;
            for (int t = 0; t < 200 && !refresh_busy; t++) @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                rd_en = 1'b1;
                rd_address = 16'(i);
                if (rd_ready) begin
                    acc++;
                    rq.push_back('{16'(i), mdl[i], 1'b0, 0});
                end else saw_full = 1'b1;
                @(negedge clk);
            end
            rd_en = 1'b0;
            check("bp_accepts", 32'(acc), 32'd4);
            check("bp_saw_full", 32'(saw_full), 32'd1);
            idle(12);
        end
`endif

        // Reset with requests queued and in flight.
        issue(0, 16'h0, 16'h0, 1, 16'h0001);
        issue(0, 16'h0, 16'h0, 1, 16'h0002);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_acks", {30'd0, wr_ret_ack, rd_ret_ack}, 32'd0);
        check("rst_mid_fields", {wr_ret_address, rd_ret_address}, 32'd0);
        check("rst_mid_data", 32'(rd_ret_data), 32'd0);
        wq.delete();
        rq.delete();
        idle(2);
        rst = 1'b0;
        post_rst_acks = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (rd_ret_ack || wr_ret_ack) post_rst_acks++;
        end
        check("post_rst_no_ack", 32'(post_rst_acks), 32'd0);
        check("post_rst_ready", {30'd0, wr_ready, rd_ready}, 32'd3);

        check("sb_drained", 32'(wq.size() + rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
